// File: rtl/float_add_pipe.sv
// Pipelined floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero, special-value handling and valid/ready flow control.
// Register chain: operand reg -> S1 (align) -> S2 (add) -> S3 (output reg).
module float_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [2:0]   out_flags
);
  localparam int STAGES = 3;
  localparam int SW     = MAN_W + 4;          // hidden + frac + G/R/S
  localparam int SHW    = $clog2(SW + 1);
  localparam int EW     = EXP_W + 2;          // signed exponent during normalise
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } in_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sa;
    logic [SW-1:0]    sb;
    logic             eff_sub;
    logic             spec;
    logic [W-1:0]     spec_val;
    logic [2:0]       spec_flags;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic             spec;
    logic [W-1:0]     spec_val;
    logic [2:0]       spec_flags;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  logic            en;
  in_t             in_r;
  s1_t             s1_c, s1_r;
  s2_t             s2_c, s2_r;
  logic [W-1:0]    res;
  logic [2:0]      flg;

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // ---------------- S1: unpack, classify, compare/swap, align ----------------
  logic             a_s, b_s, b_es;
  logic [EXP_W-1:0] a_e, b_e, big_e, sm_e, e_diff;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [MAN_W:0]   a_sig, b_sig, big_sig, sm_sig;
  logic [SHW-1:0]   sh;
  logic [2*MAN_W+3:0] wide;

  assign {a_s, a_e, a_f} = in_r.a;
  assign {b_s, b_e, b_f} = in_r.b;
  assign b_es   = b_s ^ in_r.sub;
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_nan  = (&a_e) & (|a_f);
  assign b_nan  = (&b_e) & (|b_f);
  assign a_inf  = (&a_e) & ~(|a_f);
  assign b_inf  = (&b_e) & ~(|b_f);
  // Subnormals flush to zero, so their fraction takes no part in anything.
  assign a_sig  = a_zero ? '0 : {1'b1, a_f};
  assign b_sig  = b_zero ? '0 : {1'b1, b_f};
  assign swap   = {b_e, b_sig[MAN_W-1:0]} > {a_e, a_sig[MAN_W-1:0]};
  assign big_e   = swap ? b_e : a_e;
  assign sm_e    = swap ? a_e : b_e;
  assign big_sig = swap ? b_sig : a_sig;
  assign sm_sig  = swap ? a_sig : b_sig;
  assign e_diff  = big_e - sm_e;
  // Clamp keeps the sticky bit alive for very large exponent gaps.
  assign sh   = (e_diff > EXP_W'(MAN_W + 3)) ? SHW'(MAN_W + 3) : SHW'(e_diff);
  assign wide = {sm_sig, {(MAN_W+3){1'b0}}} >> sh;

  // Build the aligned operand pair and resolve specials that bypass the datapath.
  always_comb begin
    s1_c            = '0;
    s1_c.sign       = swap ? b_es : a_s;
    s1_c.exp        = big_e;
    s1_c.sa         = {big_sig, 3'b000};
    s1_c.sb         = {wide[2*MAN_W+3 -: MAN_W+3], |wide[MAN_W:0]};
    s1_c.eff_sub    = a_s ^ b_es;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_es))) begin
      s1_c.spec       = 1'b1;
      s1_c.spec_val   = QNAN;
      s1_c.spec_flags = 3'b100;
    end else if (a_inf) begin
      s1_c.spec       = 1'b1;
      s1_c.spec_val   = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_c.spec       = 1'b1;
      s1_c.spec_val   = {b_es, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      // Only (-0)+(-0) keeps a negative sign.
      s1_c.spec       = 1'b1;
      s1_c.spec_val   = {a_s & b_es, {(W-1){1'b0}}};
    end
  end

  // ---------------- S2: significand add/sub (A >= B, so no borrow) ----------------
  always_comb begin
    s2_c            = '0;
    s2_c.sign       = s1_r.sign;
    s2_c.exp        = s1_r.exp;
    s2_c.spec       = s1_r.spec;
    s2_c.spec_val   = s1_r.spec_val;
    s2_c.spec_flags = s1_r.spec_flags;
    s2_c.sum        = s1_r.eff_sub ? ({1'b0, s1_r.sa} - {1'b0, s1_r.sb})
                                   : ({1'b0, s1_r.sa} + {1'b0, s1_r.sb});
  end

  // ---------------- S3: normalise, round, pack ----------------
  function automatic logic [SHW-1:0] lzc(input logic [SW-1:0] v);
    logic found;
    lzc   = SHW'(SW);
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc   = SHW'(SW - 1 - i);
        found = 1'b1;
      end
    end
  endfunction

  logic                 carry, rnd;
  logic [SHW-1:0]       lz;
  logic [SW-1:0]        norm;
  logic signed [EW-1:0] e_n, e_f;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac;

  // Normalise (right on carry-out, else left by lzc), round RNE, then range-check.
  always_comb begin
    carry = s2_r.sum[SW];
    lz    = lzc(s2_r.sum[SW-1:0]);
    if (carry) begin
      norm = {s2_r.sum[SW:2], s2_r.sum[1] | s2_r.sum[0]};
      e_n  = EW'(s2_r.exp) + EW'(1);
    end else begin
      norm = s2_r.sum[SW-1:0] << lz;
      e_n  = EW'(s2_r.exp) - EW'(lz);
    end
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd);
    if (mant_r[MAN_W+1]) begin
      e_f  = e_n + EW'(1);
      frac = mant_r[MAN_W:1];
    end else begin
      e_f  = e_n;
      frac = mant_r[MAN_W-1:0];
    end
    res = {s2_r.sign, e_f[EXP_W-1:0], frac};
    flg = 3'b000;
    if (s2_r.spec) begin
      res = s2_r.spec_val;
      flg = s2_r.spec_flags;
    end else if (s2_r.sum == '0) begin
      res = '0;
    end else if (e_f >= E_MAX) begin
      res = {s2_r.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 3'b010;
    end else if (e_f <= E_ZERO) begin
      res = {s2_r.sign, {(W-1){1'b0}}};
      flg = 3'b001;
    end
  end

  // Valid shift register and output register; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      out_sum   <= '0;
      out_flags <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (vld_pipe[STAGES-1]) begin
        out_sum   <= res;
        out_flags <= flg;
      end
    end
  end

  // Datapath registers carry no reset; their validity lives in vld_pipe.
  always_ff @(posedge clk) begin
    if (en) begin
      in_r <= '{sub: in_sub, a: in_a, b: in_b};
      s1_r <= s1_c;
      s2_r <= s2_c;
    end
  end
endmodule

// File: tb/tb_float_add_pipe.sv
// Scoreboard bench for float_add_pipe (EXP_W=8, MAN_W=23): the driver pushes
// hand-computed results on each accepted transfer, a monitor pops on each
// output transfer and checks hold behaviour while stalled.
module tb_float_add_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] out_sum;
  logic [2:0]  out_flags;

  float_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic [2:0]  flags;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [18] = '{
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},  // x-x -> +0
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},  // -0 + -0
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},  // tie to even
    '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000},  // above half
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010},  // overflow
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},  // inf-inf
    '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001},  // underflow
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},  // 3-1
    '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 3'b000},  // 1+(-0.5)
    '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 3'b000},  // x+0
    '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000},  // +0 + -0
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000},  // inf+1
    '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000},  // 1-inf
    '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100},  // NaN in
    '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000},  // 1-2^-24
    '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000},  // -2+1
    '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000},  // -0 - +0
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000}   // subnormal flushed
  };

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one op at the falling edge, wait (bounded) for in_ready, record the expectation.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] es, input logic [2:0] ef, input bit push);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed %b for op %h,%h", in_ready, a, b);
    end else if (push) begin
      e.sum = es; e.flags = ef;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare on each output transfer, verify outputs hold while stalled.
  initial begin
    logic        hold;
    logic [31:0] hs;
    logic [2:0]  hf;
    exp_t        e;
    hold = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_sum", out_sum, hs);
          check("hold_flags", 32'(out_flags), 32'(hf));
        end
        hold = 1'b0;
        if (out_valid) begin
          if (!out_ready) begin
            hold = 1'b1; hs = out_sum; hf = out_flags;
          end else if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_output: got %h, required no output", out_sum);
          end else begin
            e = sb.pop_front();
            check($sformatf("sum#%0d", n_out), out_sum, e.sum);
            check($sformatf("flags#%0d", n_out), 32'(out_flags), 32'(e.flags));
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Latency: accepted at edge N, valid after edge N+3
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("latency_valid_N+%0d", k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    drain();

    // Directed vectors, back-to-back
    for (int i = 0; i < 18; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].flags, 1'b1);
    drain();

    // 20-op stream with a 5-cycle downstream stall in the middle
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          if (i % 2 == 0)
            send({1'b0, 8'(128 + i), 23'd0}, {1'b0, 8'(128 + i), 23'd0}, 1'b0,
                 {1'b0, 8'(129 + i), 23'd0}, 3'b000, 1'b1);
          else
            send({1'b0, 8'(128 + i), 23'd0}, {1'b0, 8'(127 + i), 23'd0}, 1'b1,
                 {1'b0, 8'(127 + i), 23'd0}, 3'b000, 1'b1);
        end
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          if (out_valid) check($sformatf("stall_in_ready%0d", k), 32'(in_ready), 32'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: none may emerge
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 3'b000, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 32'h0, 3'b000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("flush_idle%0d", k), 32'(out_valid), 32'd0);
    end

    // New op after reset
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b1);
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
